// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types and constants for the display serializer: FSM
//             state encoding, frame geometry and the serial-clock divider
//             calculation.
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Frame geometry: six digit/segment bytes per display frame
    localparam int DIGITS   = 6;
    localparam int SEG_BITS = 8;

    // Serializer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH_HI = 3'd3,
        LATCH_LO = 3'd4
    } state_t;

    // System-clock cycles per half period of the serial clock
    function automatic int calc_half_div(input int sys_clk_hz, input int shift_clk_hz);
        return sys_clk_hz / (2 * shift_clk_hz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_shift_out_half_tick.sv
`default_nettype none
// ============================================================================
//  Module   : shift_half_tick
//  Purpose  : Half-period divider for the serial clock. Counts
//             0..HALF_DIV-1 while i_run is high and pulses o_tick on the
//             last count; held at zero while i_run is low.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_half_tick #(
    parameter int HALF_DIV = 25
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_run,
    output logic o_tick
);

    localparam int               CNT_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = i_run && (cnt_q == CNT_LAST);

    // Next count: wrap at the last count, park at zero when not running
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_run || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_shift_out.sv
`default_nettype none
// ============================================================================
//  Module   : display_shift_out
//  Purpose  : Serializes one parallel display frame MSB-first onto
//             o_serial_data / o_serial_clk and then pulses o_serial_latch so
//             the external shift-register chain transfers the word.
//             Optional macro DISPLAY_SHIFT_PENDING_EN adds a one-entry
//             pending buffer so a request made while busy is sent
//             back-to-back instead of being dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module display_shift_out
    import display_pkg::*;
#(
    parameter int SYS_CLK_HZ   = 50_000_000,
    parameter int SHIFT_CLK_HZ = 1_000_000,
    parameter int SHIFT_WIDTH  = DIGITS * SEG_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic [SHIFT_WIDTH-1:0] i_data,
    output logic                   o_busy,
    output logic                   o_serial_data,
    output logic                   o_serial_clk,
    output logic                   o_serial_latch
);

    localparam int             HALF_DIV = calc_half_div(SYS_CLK_HZ, SHIFT_CLK_HZ);
    localparam int             BCW      = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(SHIFT_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    state_t                 state_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [BCW-1:0]         bitcnt_q;
    logic                   busy_q;
    logic                   data_q;
    logic                   sclk_q;
    logic                   latch_q;

    logic                   w_tick;
    logic                   w_load_en;
    logic [SHIFT_WIDTH-1:0] w_load_word;
    logic [SHIFT_WIDTH-1:0] w_shifted;

    assign w_shifted = shift_q << 1;

    shift_half_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_half_tick (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_run     (state_q != IDLE),
        .o_tick    (w_tick)
    );

`ifdef DISPLAY_SHIFT_PENDING_EN
    logic [SHIFT_WIDTH-1:0] pend_q;
    logic                   pend_valid_q;

    // A new frame starts from IDLE on a request, or straight out of the
    // latch phase when a request is pending (a request arriving on that very
    // tick is newer than any stored one and wins)
    assign w_load_en   = ((state_q == IDLE) && i_start) ||
                         ((state_q == LATCH_LO) && w_tick && (pend_valid_q || i_start));
    assign w_load_word = i_start ? i_data : pend_q;
`else
    // Requests are only honoured in IDLE; anything while busy is dropped
    assign w_load_en   = (state_q == IDLE) && i_start;
    assign w_load_word = i_data;
`endif

    // Serializer FSM: frame capture, bit shifting and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            data_q   <= 1'b0;
            sclk_q   <= 1'b0;
            latch_q  <= 1'b0;
`ifdef DISPLAY_SHIFT_PENDING_EN
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
`endif
        end else begin
            if (w_load_en) begin
                // First bit is presented together with the busy flag
                state_q  <= SHIFT_LO;
                shift_q  <= w_load_word;
                bitcnt_q <= BIT_LAST;
                busy_q   <= 1'b1;
                data_q   <= w_load_word[SHIFT_WIDTH-1];
                sclk_q   <= 1'b0;
                latch_q  <= 1'b0;
            end else begin
                case (state_q)
                    SHIFT_LO: begin
                        if (w_tick) begin
                            state_q <= SHIFT_HI;
                            sclk_q  <= 1'b1;
                        end
                    end
                    SHIFT_HI: begin
                        if (w_tick) begin
                            sclk_q <= 1'b0;
                            if (bitcnt_q != '0) begin
                                state_q  <= SHIFT_LO;
                                shift_q  <= w_shifted;
                                data_q   <= w_shifted[SHIFT_WIDTH-1];
                                bitcnt_q <= bitcnt_q - BIT_ONE;
                            end else begin
                                // Latch rises on the same edge the clock falls
                                state_q <= LATCH_HI;
                                latch_q <= 1'b1;
                                data_q  <= 1'b0;
                            end
                        end
                    end
                    LATCH_HI: begin
                        if (w_tick) begin
                            state_q <= LATCH_LO;
                            latch_q <= 1'b0;
                        end
                    end
                    LATCH_LO: begin
                        if (w_tick) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
`ifdef DISPLAY_SHIFT_PENDING_EN
            // Pending slot: consumed on a frame start, overwritten by newer
            // requests while a frame is in flight
            if (w_load_en) begin
                pend_valid_q <= 1'b0;
            end else if (i_start && (state_q != IDLE)) begin
                pend_q       <= i_data;
                pend_valid_q <= 1'b1;
            end
`endif
        end
    end

    assign o_busy         = busy_q;
    assign o_serial_data  = data_q;
    assign o_serial_clk   = sclk_q;
    assign o_serial_latch = latch_q;

endmodule
`default_nettype wire
